// File: rtl/req_ack_responder_pkg.sv
// Shared types and defaults for the request/acknowledge responder.
package req_ack_pkg;
  typedef enum logic {IDLE, COUNT} resp_state_t;
  localparam int MAX_PEND_DEF = 8;
  localparam int LAT_W_DEF    = 4;
endpackage

// File: rtl/req_ack_responder_if.sv
// Request/ack bus between a requester (master) and the responder (slave).
interface req_ack_responder_if
  import req_ack_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int LAT_W    = LAT_W_DEF
);
  localparam int PW = $clog2(MAX_PEND + 1);

  logic             req_i;
  logic [LAT_W-1:0] lat_i;
  logic             ack_o;
  logic [PW-1:0]    pending_o;
  logic             busy_o;
  logic             overflow_o;

  modport master (output req_i, lat_i, input ack_o, pending_o, busy_o, overflow_o);
  modport slave  (input req_i, lat_i, output ack_o, pending_o, busy_o, overflow_o);
endinterface

// File: rtl/req_ack_responder_lat_fifo.sv
// In-order latency queue; head data is combinational, push on a full queue
// is only legal together with a pop on the same edge.
module lat_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/req_ack_responder.sv
// Responder: queues per-request latencies, serves them one at a time and
// emits a single-cycle registered ack for each accepted request, in order.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int LAT_W    = LAT_W_DEF
) (
  input logic                clk,
  input logic                rst,
  req_ack_responder_if.slave bus
);
  localparam int PW = $clog2(MAX_PEND + 1);

  resp_state_t      r_state, w_state_nxt;
  logic [LAT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_ovf;
  logic             w_pop, w_push, w_full, w_empty;
  logic [LAT_W-1:0] w_head;
  logic [PW-1:0]    w_count;

  // A full queue still accepts when the head leaves on the same edge.
  assign w_pop  = (r_state == IDLE) && !w_empty;
  assign w_push = bus.req_i && (!w_full || w_pop);

  lat_fifo #(.DEPTH(MAX_PEND), .WIDTH(LAT_W)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (bus.lat_i),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    case (r_state)
      IDLE: if (w_pop) begin
        w_state_nxt = COUNT;
        w_cnt_nxt   = w_head;
      end
      COUNT: if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - LAT_W'(1);
      end else begin
        w_ack_nxt   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_ovf   <= r_ovf | (bus.req_i && w_full && !w_pop);
    end
  end

  assign bus.ack_o      = r_ack;
  assign bus.busy_o     = (r_state == COUNT);
  assign bus.pending_o  = w_count;
  assign bus.overflow_o = r_ovf;
endmodule

// File: tb/tb_req_ack_responder.sv
// Directed + random bench; the model tracks service windows as edge timestamps.
module tb_req_ack_responder;
  localparam int MAXP = 8;
  localparam int LW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  req_ack_responder_if #(.MAX_PEND(MAXP), .LAT_W(LW)) bus ();
  req_ack_responder #(.MAX_PEND(MAXP), .LAT_W(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, fails = 0;
  int edge_n = 0;
  // model state: queue of latencies plus timestamps of the request in service
  int q[$];
  int free_edge = 0, pop_edge = -10, ack_edge = -10;
  bit m_ovf = 1'b0, mv = 1'b0;
  int accepted = 0, ack_total = 0, max_pend = 0;
  int ack_seen[$];
  logic exp_ack, exp_busy, exp_ovf;
  int exp_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model(input int e, input bit r, input int lat, input bit rs);
    bit popped;
    if (rs) begin
      q.delete();
      free_edge = 0; pop_edge = -10; ack_edge = -10; m_ovf = 1'b0;
    end else begin
      popped = (e >= free_edge) && (q.size() > 0);
      if (popped) begin
        pop_edge  = e;
        ack_edge  = e + 2 + q[0];
        free_edge = ack_edge;
        void'(q.pop_front());
      end
      if (r) begin
        if (q.size() < MAXP) begin q.push_back(lat); accepted++; end
        else m_ovf = 1'b1;
      end
    end
    exp_ack  = (e + 1 == ack_edge);
    exp_busy = (pop_edge < e + 1) && (e + 1 < ack_edge);
    exp_pend = q.size();
    exp_ovf  = m_ovf;
    mv = 1'b1;
  endtask

  task automatic step(input bit r, input int lat, input bit rs = 1'b0);
    int e;
    bus.req_i = r; bus.lat_i = LW'(lat); rst = rs;
    @(posedge clk);
    e = edge_n; edge_n = e + 1;
    model(e, r, lat, rs);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic do_reset();
    step(1'b0, 0, 1'b1); step(1'b0, 0, 1'b1);
  endtask

  always @(negedge clk) if (mv) begin
    chk("ack_o", bus.ack_o, exp_ack);
    chk("busy_o", bus.busy_o, exp_busy);
    chk("pending_o", bus.pending_o, exp_pend);
    chk("overflow_o", bus.overflow_o, exp_ovf);
    if (bus.ack_o === 1'b1) begin ack_seen.push_back(edge_n); ack_total++; end
    if (int'(bus.pending_o) > max_pend) max_pend = int'(bus.pending_o);
  end

  initial begin
    int b, acc0, ack0;
    bus.req_i = 1'b0; bus.lat_i = '0; rst = 1'b1;
    do_reset(); idle(2);
    @(negedge clk);
    chk("reset_ack", bus.ack_o, 0);
    chk("reset_pending", bus.pending_o, 0);

    // isolated request, L=0: ack 3 edges later
    ack_seen.delete(); b = edge_n;
    step(1'b1, 0); idle(8);
    chk("iso0_nacks", ack_seen.size(), 1);
    if (ack_seen.size() > 0) chk("iso0_edge", ack_seen[0], b + 3);

    // isolated request, L=5
    ack_seen.delete(); b = edge_n;
    step(1'b1, 5); idle(12);
    chk("iso5_nacks", ack_seen.size(), 1);
    if (ack_seen.size() > 0) chk("iso5_edge", ack_seen[0], b + 8);

    // three back-to-back requests, L=2,0,1
    ack_seen.delete(); max_pend = 0; b = edge_n;
    step(1'b1, 2); step(1'b1, 0); step(1'b1, 1); idle(12);
    chk("b2b_nacks", ack_seen.size(), 3);
    if (ack_seen.size() == 3) begin
      chk("b2b_ack0", ack_seen[0], b + 5);
      chk("b2b_ack1", ack_seen[1], b + 7);
      chk("b2b_ack2", ack_seen[2], b + 10);
    end
    chk("b2b_maxpend", max_pend, 2);

    // overflow: 10 requests of L=15 into an 8-deep queue
    ack_seen.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 15);
    chk("ovf_set", bus.overflow_o, 1);
    idle(170);
    chk("ovf_nacks", ack_seen.size(), 9);
    chk("ovf_sticky", bus.overflow_o, 1);

    // reset with requests outstanding and a request on the reset edge
    do_reset(); idle(2);
    ack_seen.delete();
    step(1'b1, 5); step(1'b1, 5); step(1'b1, 5); idle(1);
    step(1'b1, 3, 1'b1);
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_pend", bus.pending_o, 0);
    chk("rst_ovf", bus.overflow_o, 0);
    idle(30);
    chk("rst_noack", ack_seen.size(), 0);
    b = edge_n; step(1'b1, 0); idle(6);
    chk("rst_new_n", ack_seen.size(), 1);
    if (ack_seen.size() > 0) chk("rst_new_edge", ack_seen[0], b + 3);

    // random traffic, then drain
    acc0 = accepted; ack0 = ack_total;
    for (int i = 0; i < 1000; i++)
      step($urandom_range(0, 2) == 0, int'($urandom_range(0, 15)));
    idle(200);
    chk("rand_ackcount", ack_total - ack0, accepted - acc0);

    mv = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
